red_pitaya_sat_integrator: RTL and testbench
============================================

# red_pitaya_sat_integrator

Saturating accumulator stage that consumes the scaled product and overflow flag of the saturating multiplier feeding it, as used in the PID integral path and the IQ-demodulator low-pass path. Accumulates signed samples into a wide register that clamps instead of wrapping, then rescales and saturates the result to the output width. It also counts saturation events for the register bank.

## Interface
Parameters:
- BITS_IN, 16: width of the signed input sample (the multiplier output width).
- BITS_ACC, 24: signed accumulator width. Must be > BITS_IN.
- BITS_OUT, 14: signed output width.
- SHIFT, 8: right shift from accumulator to output. Requires BITS_ACC-SHIFT >= BITS_OUT.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk_i, input, 1: system clock. All state changes on its rising edge.
  - rst_i, input, 1: reset.
- Data input:
  - data_i, input, BITS_IN: signed sample from the multiplier.
  - valid_i, input, 1: data_i is valid this cycle.
  - ovf_i, input, 1: upstream overflow flag, qualified by valid_i.
- Control:
  - hold_i, input, 1: freeze the accumulator.
  - clear_i, input, 1: set the accumulator to 0.
  - set_i, input, 1: load set_val_i into the accumulator.
  - set_val_i, input, BITS_ACC: signed preload value.
  - cnt_clr_i, input, 1: clear the event counter.
- Outputs:
  - data_o, output, BITS_OUT: registered, saturated value of acc>>>SHIFT.
  - valid_o, output, 1: valid_i delayed by 2 cycles.
  - sat_o, output, 1: accumulator clamped at the last accumulate.
  - acc_o, output, BITS_ACC: raw accumulator, for register readback.
  - ovf_cnt_o, output, 16: saturating event count.

## Operation
- Accumulator update priority per cycle: rst_i > clear_i > set_i > hold_i > accumulate.
  - accumulate occurs only when valid_i=1. Otherwise acc holds.
- Accumulate arithmetic:
  - sum = acc + sign-extended data_i, computed in BITS_ACC+1 bits.
  - If sum > 2^(BITS_ACC-1)-1, acc = that maximum and sat_o=1.
  - If sum < -2^(BITS_ACC-1), acc = that minimum and sat_o=1.
  - Otherwise acc = sum and sat_o=0.
  - sat_o holds its value on non-accumulate cycles. clear_i, set_i and rst_i force sat_o=0.
- set_val_i is loaded verbatim; no clamping is needed because it is already BITS_ACC wide.
- Output stage:
  - s = acc[BITS_ACC-1:SHIFT].
  - If s exceeds the BITS_OUT signed range, data_o = +max (0x1FFF at defaults) or -min (0x2000 at defaults).
  - Otherwise data_o = s truncated to BITS_OUT.
  - Rounding is truncation toward −∞.
- Event counter:
  - Increments by 1 on each accumulate cycle where ovf_i=1 or a clamp occurs. A cycle with both events counts once.
  - Saturates at 0xFFFF; it never wraps.
  - cnt_clr_i or rst_i forces 0 and wins over a simultaneous event.
  - hold_i does not block counting of ovf_i when valid_i=1. A held cycle never clamps.
- Reset values: acc=0, data_o=0, valid_o=0, sat_o=0, ovf_cnt_o=0, pipeline valid bits=0.
  - Reset asserted mid-accumulation discards the in-flight samples. valid_o is 0 on the cycle after reset.

## Timing
- Stage 1 register: acc, sat_o, ovf_cnt_o. These update on the edge at which valid_i is sampled, so acc_o shows the new value 1 cycle after the input.
- Stage 2 register: data_o, computed from the stage-1 acc. It is valid 2 cycles after the input, together with valid_o.
- Throughput: one sample per clock. No backpressure.
- clear_i and set_i take effect in acc_o 1 cycle later and in data_o 2 cycles later. They apply regardless of valid_i.
- The critical path is one BITS_ACC+1 adder plus compare/mux. No multiplier lives in this block.

## Structure
- Shared package:
  - Helper constants for the signed max/min of a given width.
  - Event-counter width (16).
  - Both are reused by the PID and IQ blocks.
- One natural sub-module, red_pitaya_sat_shift. It is the combinational rescale-and-saturate used by the output stage, and it is reusable elsewhere.
- Everything else lives in one module: two register stages and the counter.

## Test plan
- Reset: apply rst_i for 3 cycles with valid_i=1 and data_i=1000 -> all outputs 0; valid_o=0 until 2 cycles after release.
- Accumulate: data_i=256, valid_i=1 for 10 cycles -> acc_o=2560; data_o=10 with valid_o 2 cycles after the last input; sat_o=0.
- Positive clamp: data_i=32767 for 300 cycles.
  - Cycle 256: acc_o=8388352.
  - Cycles 257–300: acc_o=8388607 and sat_o=1.
  - ovf_cnt_o=44 at the end.
  - data_o=8191 from the point acc>>8 exceeds 8191.
- Priority: acc=5000, then set_i=1 with set_val_i=-1000 and clear_i=1 in the same cycle -> acc_o=0. Next cycle, set_i only -> acc_o=-1000 and data_o=-4. Then hold_i=1 with data_i=50 -> acc_o stays -1000.
- Counter:
  - ovf_i=1 with valid_i=1 for 70000 cycles -> ovf_cnt_o=65535.
  - cnt_clr_i together with an event -> 0 next cycle.
  - ovf_i=1 with valid_i=0 -> no count.
- Negative clamp, then reset mid-run: data_i=-32768 for 260 cycles -> acc_o=-8388608, data_o=-8192. Then a 1-cycle rst_i during streaming -> acc_o=0 and sat_o=0 next cycle.

Source files
------------

// File: rtl/red_pitaya_sat_integrator_pkg.sv
// Shared constants for the saturating arithmetic blocks (integrator, PID, IQ paths).
// Signed range helpers are evaluated at elaboration time only.
package red_pitaya_sat_integrator_pkg;

  localparam int CNT_W = 16;

  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/red_pitaya_sat_integrator_if.sv
// Sample stream, control strobes and readback bundle of the saturating integrator.
// master drives samples/controls, slave is the integrator.
interface red_pitaya_sat_integrator_if #(
  parameter int BITS_IN  = 16,
  parameter int BITS_ACC = 24,
  parameter int BITS_OUT = 14
);
  import red_pitaya_sat_integrator_pkg::*;

  logic signed [BITS_IN-1:0]  data_i;
  logic                       valid_i;
  logic                       ovf_i;
  logic                       hold_i;
  logic                       clear_i;
  logic                       set_i;
  logic signed [BITS_ACC-1:0] set_val_i;
  logic                       cnt_clr_i;

  logic signed [BITS_OUT-1:0] data_o;
  logic                       valid_o;
  logic                       sat_o;
  logic signed [BITS_ACC-1:0] acc_o;
  logic [CNT_W-1:0]           ovf_cnt_o;

  modport master (
    output data_i, valid_i, ovf_i, hold_i, clear_i, set_i, set_val_i, cnt_clr_i,
    input  data_o, valid_o, sat_o, acc_o, ovf_cnt_o
  );

  modport slave (
    input  data_i, valid_i, ovf_i, hold_i, clear_i, set_i, set_val_i, cnt_clr_i,
    output data_o, valid_o, sat_o, acc_o, ovf_cnt_o
  );

endinterface

// File: rtl/red_pitaya_sat_shift.sv
// Combinational rescale-and-saturate: arithmetic right shift (floor) then clamp
// into a narrower signed range.
module red_pitaya_sat_shift
  import red_pitaya_sat_integrator_pkg::*;
#(
  parameter int BITS_IN  = 24,
  parameter int BITS_OUT = 14,
  parameter int SHIFT    = 8
) (
  input  logic signed [BITS_IN-1:0]  din,
  output logic signed [BITS_OUT-1:0] dout
);

  localparam int W = BITS_IN - SHIFT;
  localparam logic signed [BITS_OUT-1:0] OUT_MAX = BITS_OUT'(smax(BITS_OUT));
  localparam logic signed [BITS_OUT-1:0] OUT_MIN = BITS_OUT'(smin(BITS_OUT));

  logic signed [W-1:0] s;
  logic                unused_lsb;

  // dropping the low bits of a two's complement value rounds toward -inf
  assign s          = din[BITS_IN-1:SHIFT];
  assign unused_lsb = ^din[SHIFT-1:0];

  generate
    if (W > BITS_OUT) begin : g_sat
      logic ovf;
      // in range only when all bits above the output sign bit match it
      assign ovf  = ~((&s[W-1:BITS_OUT-1]) | ~(|s[W-1:BITS_OUT-1]));
      assign dout = ovf ? (s[W-1] ? OUT_MIN : OUT_MAX) : s[BITS_OUT-1:0];
    end else begin : g_pass
      assign dout = s;
    end
  endgenerate

endmodule

// File: rtl/red_pitaya_sat_integrator.sv
// Clamping accumulator with registered rescale/saturate output stage and a
// saturating event counter for register readback.
module red_pitaya_sat_integrator
  import red_pitaya_sat_integrator_pkg::*;
#(
  parameter int BITS_IN  = 16,
  parameter int BITS_ACC = 24,
  parameter int BITS_OUT = 14,
  parameter int SHIFT    = 8
) (
  input logic                         clk_i,
  input logic                         rst_i,
  red_pitaya_sat_integrator_if.slave  bus
);

  localparam int STAGES = 2;
  localparam logic signed [BITS_ACC:0]   SUM_MAX = (BITS_ACC+1)'(smax(BITS_ACC));
  localparam logic signed [BITS_ACC:0]   SUM_MIN = (BITS_ACC+1)'(smin(BITS_ACC));
  localparam logic signed [BITS_ACC-1:0] ACC_MAX = BITS_ACC'(smax(BITS_ACC));
  localparam logic signed [BITS_ACC-1:0] ACC_MIN = BITS_ACC'(smin(BITS_ACC));

  logic signed [BITS_ACC-1:0] acc, acc_sat;
  logic signed [BITS_ACC:0]   sum;
  logic                       sat, hi, lo, accum, ev;
  logic [CNT_W-1:0]           cnt;
  logic [STAGES:1]            vld_pipe;
  logic signed [BITS_OUT-1:0] dout, dout_c;

  // one extra bit of headroom so the clamp compare sees the true sum
  assign sum   = {acc[BITS_ACC-1], acc}
               + {{(BITS_ACC+1-BITS_IN){bus.data_i[BITS_IN-1]}}, bus.data_i};
  assign hi    = (sum > SUM_MAX);
  assign lo    = (sum < SUM_MIN);
  assign acc_sat = hi ? ACC_MAX : lo ? ACC_MIN : sum[BITS_ACC-1:0];

  assign accum = bus.valid_i & ~bus.clear_i & ~bus.set_i & ~bus.hold_i;
  // upstream overflow counts on any valid cycle; a clamp only on a real accumulate
  assign ev    = (bus.valid_i & bus.ovf_i) | (accum & (hi | lo));

  red_pitaya_sat_shift #(
    .BITS_IN  (BITS_ACC),
    .BITS_OUT (BITS_OUT),
    .SHIFT    (SHIFT)
  ) u_shift (
    .din  (acc),
    .dout (dout_c)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc      <= '0;
      sat      <= 1'b0;
      cnt      <= '0;
      vld_pipe <= '0;
      dout     <= '0;
    end else begin
      if (bus.clear_i) begin
        acc <= '0;
        sat <= 1'b0;
      end else if (bus.set_i) begin
        acc <= bus.set_val_i;
        sat <= 1'b0;
      end else if (accum) begin
        acc <= acc_sat;
        sat <= hi | lo;
      end

      if (bus.cnt_clr_i)
        cnt <= '0;
      else if (ev && cnt != '1)
        cnt <= cnt + CNT_W'(1);

      vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_i};
      dout     <= dout_c;
    end
  end

  assign bus.data_o    = dout;
  assign bus.valid_o   = vld_pipe[STAGES];
  assign bus.sat_o     = sat;
  assign bus.acc_o     = acc;
  assign bus.ovf_cnt_o = cnt;

endmodule

// File: tb/tb_red_pitaya_sat_integrator.sv
// Directed bench: stimulus pushes expected data_o per valid sample into a queue,
// a negedge monitor pops on valid_o; register readback checked against hand values.
module tb_red_pitaya_sat_integrator;

  localparam longint MAXA = 8388607;
  localparam longint MINA = -8388608;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  longint expq[$];
  longint macc = 0;
  int     mcnt = 0;

  red_pitaya_sat_integrator_if #(.BITS_IN(16), .BITS_ACC(24), .BITS_OUT(14)) bus ();

  red_pitaya_sat_integrator #(
    .BITS_IN(16), .BITS_ACC(24), .BITS_OUT(14), .SHIFT(8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint exp_out(input longint a);
    longint s;
    s = a >>> 8;
    if (s > 8191) s = 8191;
    else if (s < -8192) s = -8192;
    return s;
  endfunction

  // one clock: model the accumulator for the expected-output queue
  task automatic step();
    bit     ev;
    longint s;
    @(posedge clk);
    ev = 1'b0;
    if (rst) begin
      macc = 0; mcnt = 0;
      expq.delete();
    end else begin
      if (bus.clear_i) macc = 0;
      else if (bus.set_i) macc = longint'($signed(bus.set_val_i));
      else if (!bus.hold_i && bus.valid_i) begin
        s = macc + longint'($signed(bus.data_i));
        if (s > MAXA) begin macc = MAXA; ev = 1'b1; end
        else if (s < MINA) begin macc = MINA; ev = 1'b1; end
        else macc = s;
      end
      if (bus.valid_i && bus.ovf_i) ev = 1'b1;
      if (bus.cnt_clr_i) mcnt = 0;
      else if (ev && mcnt < 65535) mcnt++;
      if (bus.valid_i) expq.push_back(exp_out(macc));
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got valid_o=1 expected no output (data_o=%0d)", $signed(bus.data_o));
      end else begin
        chk("data_o_stream", longint'($signed(bus.data_o)), expq.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.data_i = 16'sd1000; bus.valid_i = 1'b1; bus.ovf_i = 1'b0;
    bus.hold_i = 1'b0; bus.clear_i = 1'b0; bus.set_i = 1'b0;
    bus.set_val_i = '0; bus.cnt_clr_i = 1'b0;

    // reset with live input
    repeat (3) step();
    chk("rst_acc",   longint'($signed(bus.acc_o)), 0);
    chk("rst_data",  longint'($signed(bus.data_o)), 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_sat",   bus.sat_o, 0);
    chk("rst_cnt",   bus.ovf_cnt_o, 0);
    rst = 1'b0; bus.valid_i = 1'b0;
    step(); chk("post_rst_valid1", bus.valid_o, 0);
    step(); chk("post_rst_valid2", bus.valid_o, 0);

    // plain accumulate
    bus.data_i = 16'sd256; bus.valid_i = 1'b1;
    repeat (10) step();
    chk("acc_2560", longint'($signed(bus.acc_o)), 2560);
    chk("acc_sat0", bus.sat_o, 0);
    bus.valid_i = 1'b0;
    step();
    chk("acc_data10",  longint'($signed(bus.data_o)), 10);
    chk("acc_valid_o", bus.valid_o, 1);
    step();

    // positive clamp
    bus.clear_i = 1'b1; step(); bus.clear_i = 1'b0;
    bus.data_i = 16'sd32767; bus.valid_i = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 256) chk("pos_acc_256", longint'($signed(bus.acc_o)), 8388352);
      if (i == 257) begin
        chk("pos_acc_257", longint'($signed(bus.acc_o)), MAXA);
        chk("pos_sat_257", bus.sat_o, 1);
      end
    end
    chk("pos_acc_end", longint'($signed(bus.acc_o)), MAXA);
    chk("pos_sat_end", bus.sat_o, 1);
    chk("pos_cnt_44",  bus.ovf_cnt_o, 44);
    chk("pos_data",    longint'($signed(bus.data_o)), 8191);
    bus.valid_i = 1'b0; step(); step();

    // control priority
    bus.set_i = 1'b1; bus.set_val_i = 24'sd5000; step();
    chk("pri_set5000", longint'($signed(bus.acc_o)), 5000);
    bus.clear_i = 1'b1; bus.set_val_i = -24'sd1000; step();
    chk("pri_clear_wins", longint'($signed(bus.acc_o)), 0);
    chk("pri_clear_sat",  bus.sat_o, 0);
    bus.clear_i = 1'b0; step();
    chk("pri_set_m1000", longint'($signed(bus.acc_o)), -1000);
    bus.set_i = 1'b0; bus.hold_i = 1'b1; bus.data_i = 16'sd50; bus.valid_i = 1'b1; step();
    chk("pri_hold_acc",  longint'($signed(bus.acc_o)), -1000);
    chk("pri_data_m4",   longint'($signed(bus.data_o)), -4);
    chk("pri_hold_cnt",  bus.ovf_cnt_o, 44);
    bus.hold_i = 1'b0; bus.valid_i = 1'b0; step(); step();

    // event counter saturation and clear
    bus.cnt_clr_i = 1'b1; step(); bus.cnt_clr_i = 1'b0;
    chk("cnt_clr", bus.ovf_cnt_o, 0);
    bus.data_i = 16'sd0; bus.ovf_i = 1'b1; bus.valid_i = 1'b1;
    repeat (70000) step();
    chk("cnt_sat", bus.ovf_cnt_o, 65535);
    chk("cnt_acc_unchanged", longint'($signed(bus.acc_o)), -1000);
    bus.cnt_clr_i = 1'b1; step(); bus.cnt_clr_i = 1'b0;
    chk("cnt_clr_wins", bus.ovf_cnt_o, 0);
    bus.valid_i = 1'b0; step();
    chk("cnt_no_valid", bus.ovf_cnt_o, 0);
    bus.valid_i = 1'b1; step();
    chk("cnt_one", bus.ovf_cnt_o, 1);
    bus.ovf_i = 1'b0; bus.valid_i = 1'b0; step(); step();

    // negative clamp then reset while streaming
    bus.clear_i = 1'b1; step(); bus.clear_i = 1'b0;
    bus.data_i = -16'sd32768; bus.valid_i = 1'b1;
    repeat (260) step();
    chk("neg_acc",  longint'($signed(bus.acc_o)), MINA);
    chk("neg_sat",  bus.sat_o, 1);
    chk("neg_data", longint'($signed(bus.data_o)), -8192);
    chk("neg_cnt",  bus.ovf_cnt_o, 5);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_acc",   longint'($signed(bus.acc_o)), 0);
    chk("midrst_sat",   bus.sat_o, 0);
    chk("midrst_cnt",   bus.ovf_cnt_o, 0);
    chk("midrst_valid", bus.valid_o, 0);
    repeat (3) step();
    chk("restart_acc", longint'($signed(bus.acc_o)), -98304);
    bus.valid_i = 1'b0;
    repeat (3) step();
    chk("queue_drained", expq.size(), 0);
    chk("model_cnt", bus.ovf_cnt_o, mcnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
